// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode, register file, hazard unit and ID/EX register.
// Optional macro ID_FORWARD_EN: forwarding selects instead of RAW stalls.
module id_stage_pipe #(
  parameter int WORD_LEN          = 16,
  parameter int REG_FILE_SIZE     = 16,
  parameter int REG_FILE_ADDR_LEN = 4,
  parameter int EXE_CMD_LEN       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WORD_LEN-1:0]          instruction,
  input  logic                         writeEn,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest,
  input  logic [REG_FILE_SIZE-1:0]     writeVal,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_EXE,
  input  logic                         WB_EN_EXE,
  input  logic                         MEM_R_EN_EXE,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_MEM,
  input  logic                         WB_EN_MEM,
  input  logic                         flagZ,
  input  logic                         ex_stall,
  output logic                         id_stall,
  output logic                         hazard_detected,
  output logic                         brTaken,
  output logic [REG_FILE_SIZE-1:0]     br_offset,
  output logic                         ex_valid,
  output logic [EXE_CMD_LEN-1:0]       ex_EXE_CMD,
  output logic                         ex_MEM_R_EN,
  output logic                         ex_MEM_W_EN,
  output logic                         ex_WB_EN,
  output logic                         ex_is_imm,
  output logic [REG_FILE_ADDR_LEN-1:0] ex_dest,
  output logic [REG_FILE_ADDR_LEN-1:0] ex_src1,
  output logic [REG_FILE_ADDR_LEN-1:0] ex_src2,
  output logic [REG_FILE_SIZE-1:0]     ex_val1,
  output logic [REG_FILE_SIZE-1:0]     ex_val2,
  output logic [REG_FILE_SIZE-1:0]     ex_imm,
  output logic [1:0]                   ex_fwd_sel1,
  output logic [1:0]                   ex_fwd_sel2
);

  localparam int AW    = REG_FILE_ADDR_LEN;
  localparam int DW    = REG_FILE_SIZE;
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] OP_CMP = 4'b0101;

  typedef struct packed {
    logic                   valid;
    logic [EXE_CMD_LEN-1:0] cmd;
    logic                   mem_r;
    logic                   mem_w;
    logic                   wb;
    logic                   is_imm;
    logic [AW-1:0]          dst;
    logic [AW-1:0]          src1;
    logic [AW-1:0]          src2;
    logic [DW-1:0]          val1;
    logic [DW-1:0]          val2;
    logic [DW-1:0]          imm;
    logic [1:0]             fwd1;
    logic [1:0]             fwd2;
  } id_ex_t;

  id_ex_t q, dec;

  logic [3:0]    opcode;
  logic [AW-1:0] rd_f, rs1_f, rs2_f, src2;
  logic [DW-1:0] imm, val1, val2;
  logic          op_alu, op_cmp, op_movi, op_movr;
  logic          op_ld, op_st, op_beq, op_bne, op_br;
  logic          wb_d, mr_d, mw_d, imm_d, use1, use2;
  logic          hit_e1, hit_e2, load_use, flag_hz;
  logic [1:0]    fwd1, fwd2;
  logic [DW-1:0] rf [DEPTH];

  assign opcode = instruction[WORD_LEN-1 -: 4];
  assign rd_f   = instruction[WORD_LEN-5 -: AW];
  assign rs1_f  = instruction[WORD_LEN-5-AW -: AW];
  assign rs2_f  = instruction[WORD_LEN-5-2*AW -: AW];

  assign op_alu  = opcode[3:2] == 2'b00;
  assign op_cmp  = opcode == OP_CMP;
  assign op_movi = opcode == 4'b0110;
  assign op_movr = opcode == 4'b0111;
  assign op_beq  = opcode == 4'b1000;
  assign op_bne  = opcode == 4'b1001;
  assign op_br   = op_beq | op_bne;
  assign op_ld   = opcode == 4'b1100;
  assign op_st   = opcode == 4'b1101;

  // Control decode; unlisted opcodes fall through as NOP
  always_comb begin
    wb_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    imm_d = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    unique case (1'b1)
      op_alu: begin
        wb_d = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      op_cmp: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      op_movi: begin
        wb_d  = 1'b1;
        imm_d = 1'b1;
      end
      op_movr: begin
        wb_d = 1'b1;
        use1 = 1'b1;
      end
      op_ld: begin
        mr_d = 1'b1;
        wb_d = 1'b1;
        use1 = 1'b1;
      end
      op_st: begin
        mw_d = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      default: ;
    endcase
  end

  // STORE sends the rd register as its data operand
  assign src2 = op_st ? rd_f : rs2_f;
  assign imm  = DW'($signed(rs2_f));

  // Register file: async clear, R0 never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (writeEn && dest != '0) begin
      rf[dest] <= writeVal;
    end
  end

  assign val1 = (rs1_f == '0) ? '0 :
                (writeEn && dest == rs1_f) ? writeVal : rf[rs1_f];
  assign val2 = (src2 == '0) ? '0 :
                (writeEn && dest == src2) ? writeVal : rf[src2];

  assign hit_e1   = use1 & WB_EN_EXE & (dest_EXE == rs1_f)
                  & (rs1_f != '0);
  assign hit_e2   = use2 & WB_EN_EXE & (dest_EXE == src2)
                  & (src2 != '0);
  assign load_use = MEM_R_EN_EXE & (hit_e1 | hit_e2);
  assign flag_hz  = op_br & q.valid
                  & (q.cmd == EXE_CMD_LEN'(OP_CMP));

`ifdef ID_FORWARD_EN
  assign hazard_detected = in_valid & (load_use | flag_hz);

  assign fwd1 = (rs1_f == '0) ? 2'b00 :
                (WB_EN_EXE && dest_EXE == rs1_f) ? 2'b01 :
                (WB_EN_MEM && dest_MEM == rs1_f) ? 2'b10 : 2'b00;
  assign fwd2 = (src2 == '0) ? 2'b00 :
                (WB_EN_EXE && dest_EXE == src2) ? 2'b01 :
                (WB_EN_MEM && dest_MEM == src2) ? 2'b10 : 2'b00;
`else
  logic hit_m1, hit_m2;

  assign hit_m1 = use1 & WB_EN_MEM & (dest_MEM == rs1_f)
                & (rs1_f != '0);
  assign hit_m2 = use2 & WB_EN_MEM & (dest_MEM == src2)
                & (src2 != '0);

  assign hazard_detected = in_valid & (load_use | flag_hz
                         | hit_e1 | hit_e2 | hit_m1 | hit_m2);

  assign fwd1 = 2'b00;
  assign fwd2 = 2'b00;
`endif

  assign id_stall  = hazard_detected | ex_stall;
  assign br_offset = imm;
  assign brTaken   = in_valid & ~hazard_detected & ~ex_stall
                   & ((op_beq & flagZ) | (op_bne & ~flagZ));

  // Next ID/EX entry: bubble when idle or hazarded
  always_comb begin
    dec = '0;
    if (in_valid && !hazard_detected) begin
      dec.valid  = 1'b1;
      dec.cmd    = EXE_CMD_LEN'(opcode);
      dec.mem_r  = mr_d;
      dec.mem_w  = mw_d;
      dec.wb     = wb_d;
      dec.is_imm = imm_d;
      dec.dst    = rd_f;
      dec.src1   = rs1_f;
      dec.src2   = src2;
      dec.val1   = val1;
      dec.val2   = val2;
      dec.imm    = imm;
      dec.fwd1   = fwd1;
      dec.fwd2   = fwd2;
    end
  end

  // ID/EX register, held while EXE back-pressures
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (!ex_stall) begin
      q <= dec;
    end
  end

  assign ex_valid    = q.valid;
  assign ex_EXE_CMD  = q.cmd;
  assign ex_MEM_R_EN = q.mem_r;
  assign ex_MEM_W_EN = q.mem_w;
  assign ex_WB_EN    = q.wb;
  assign ex_is_imm   = q.is_imm;
  assign ex_dest     = q.dst;
  assign ex_src1     = q.src1;
  assign ex_src2     = q.src2;
  assign ex_val1     = q.val1;
  assign ex_val2     = q.val2;
  assign ex_imm      = q.imm;
  assign ex_fwd_sel1 = q.fwd1;
  assign ex_fwd_sel2 = q.fwd2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: vector table, directed corner sequences and
// random stimulus against a behavioural model of id_stage_pipe.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] instruction;
  logic        writeEn;
  logic [3:0]  dest;
  logic [15:0] writeVal;
  logic [3:0]  dest_EXE;
  logic        WB_EN_EXE;
  logic        MEM_R_EN_EXE;
  logic [3:0]  dest_MEM;
  logic        WB_EN_MEM;
  logic        flagZ;
  logic        ex_stall;
  logic        id_stall;
  logic        hazard_detected;
  logic        brTaken;
  logic [15:0] br_offset;
  logic        ex_valid;
  logic [3:0]  ex_EXE_CMD;
  logic        ex_MEM_R_EN;
  logic        ex_MEM_W_EN;
  logic        ex_WB_EN;
  logic        ex_is_imm;
  logic [3:0]  ex_dest;
  logic [3:0]  ex_src1;
  logic [3:0]  ex_src2;
  logic [15:0] ex_val1;
  logic [15:0] ex_val2;
  logic [15:0] ex_imm;
  logic [1:0]  ex_fwd_sel1;
  logic [1:0]  ex_fwd_sel2;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .instruction(instruction), .writeEn(writeEn),
    .dest(dest), .writeVal(writeVal),
    .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE),
    .MEM_R_EN_EXE(MEM_R_EN_EXE), .dest_MEM(dest_MEM),
    .WB_EN_MEM(WB_EN_MEM), .flagZ(flagZ),
    .ex_stall(ex_stall), .id_stall(id_stall),
    .hazard_detected(hazard_detected), .brTaken(brTaken),
    .br_offset(br_offset), .ex_valid(ex_valid),
    .ex_EXE_CMD(ex_EXE_CMD), .ex_MEM_R_EN(ex_MEM_R_EN),
    .ex_MEM_W_EN(ex_MEM_W_EN), .ex_WB_EN(ex_WB_EN),
    .ex_is_imm(ex_is_imm), .ex_dest(ex_dest),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_imm(ex_imm),
    .ex_fwd_sel1(ex_fwd_sel1), .ex_fwd_sel2(ex_fwd_sel2)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        is_imm;
    logic [3:0]  dst;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] imm;
    logic [1:0]  f1;
    logic [1:0]  f2;
  } bnd_t;

  typedef struct packed {
    logic [15:0] instr;
    logic        iv;
    logic        fz;
    logic        we;
    logic [3:0]  wd;
    logic [15:0] wv;
    logic        mre;
    logic        wbe;
    logic [3:0]  de;
    logic        stall;
    logic        e_hz;
    logic        e_br;
    logic        e_valid;
    logic        e_wb;
    logic [15:0] e_v1;
    logic [15:0] e_v2;
  } vec_t;

  bnd_t        m_ex;
  logic [15:0] m_rf [16];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bnd_t dut_bnd();
    bnd_t b;
    b.valid = ex_valid;    b.cmd = ex_EXE_CMD;
    b.mr = ex_MEM_R_EN;    b.mw = ex_MEM_W_EN;
    b.wb = ex_WB_EN;       b.is_imm = ex_is_imm;
    b.dst = ex_dest;       b.s1 = ex_src1;
    b.s2 = ex_src2;        b.v1 = ex_val1;
    b.v2 = ex_val2;        b.imm = ex_imm;
    b.f1 = ex_fwd_sel1;    b.f2 = ex_fwd_sel2;
    return b;
  endfunction

  function automatic logic [15:0] sext(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

  function automatic logic [15:0] rd_reg(input logic [3:0] r);
    if (r == 4'd0) return 16'd0;
    if (writeEn && dest == r) return writeVal;
    return m_rf[r];
  endfunction

  function automatic logic [1:0] m_fwd(input logic [3:0] s);
    if (s == 4'd0) return 2'b00;
    if (WB_EN_EXE && dest_EXE == s) return 2'b01;
    if (WB_EN_MEM && dest_MEM == s) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_hazard();
    logic [3:0] op;
    logic [3:0] s [2];
    logic       u [2];
    logic       hz;
    op   = instruction[15:12];
    s[0] = instruction[7:4];
    s[1] = (op == 4'd13) ? instruction[11:8] : instruction[3:0];
    u[0] = op inside {0, 1, 2, 3, 5, 7, 12, 13};
    u[1] = op inside {0, 1, 2, 3, 5, 13};
    hz   = (op == 4'd8 || op == 4'd9) && m_ex.valid
         && m_ex.cmd == 4'd5;
    for (int i = 0; i < 2; i++) begin
      if (u[i] && s[i] != 4'd0) begin
        if (MEM_R_EN_EXE && WB_EN_EXE && dest_EXE == s[i]) hz = 1'b1;
`ifndef ID_FORWARD_EN
        if (WB_EN_EXE && dest_EXE == s[i]) hz = 1'b1;
        if (WB_EN_MEM && dest_MEM == s[i]) hz = 1'b1;
`endif
      end
    end
    return in_valid && hz;
  endfunction

  function automatic logic [18:0] m_comb();
    logic [3:0] op;
    logic       hz, br;
    op = instruction[15:12];
    hz = m_hazard();
    br = in_valid && !hz && !ex_stall
       && ((op == 4'd8 && flagZ) || (op == 4'd9 && !flagZ));
    return {hz, br, hz | ex_stall, sext(instruction[3:0])};
  endfunction

  function automatic bnd_t m_next();
    bnd_t       b;
    logic [3:0] op;
    b  = '0;
    op = instruction[15:12];
    if (ex_stall) return m_ex;
    if (!in_valid || m_hazard()) return b;
    b.valid  = 1'b1;
    b.cmd    = op;
    b.wb     = op inside {0, 1, 2, 3, 6, 7, 12};
    b.mr     = op == 4'd12;
    b.mw     = op == 4'd13;
    b.is_imm = op == 4'd6;
    b.dst    = instruction[11:8];
    b.s1     = instruction[7:4];
    b.s2     = (op == 4'd13) ? instruction[11:8] : instruction[3:0];
    b.v1     = rd_reg(b.s1);
    b.v2     = rd_reg(b.s2);
    b.imm    = sext(instruction[3:0]);
`ifdef ID_FORWARD_EN
    b.f1     = m_fwd(b.s1);
    b.f2     = m_fwd(b.s2);
`endif
    return b;
  endfunction

  task automatic idle();
    in_valid = 0; instruction = '0; writeEn = 0; dest = '0;
    writeVal = '0; dest_EXE = '0; WB_EN_EXE = 0;
    MEM_R_EN_EXE = 0; dest_MEM = '0; WB_EN_MEM = 0;
    flagZ = 0; ex_stall = 0;
  endtask

  // One clock: comb check at negedge, bundle check 1 after posedge
  task automatic step();
    bnd_t        eb;
    logic [18:0] ec;
    @(negedge clk);
    ec = m_comb();
    check("comb", {hazard_detected, brTaken, id_stall, br_offset}, ec);
    eb = m_next();
    if (writeEn && dest != 4'd0) m_rf[dest] = writeVal;
    @(posedge clk);
    #1;
    m_ex = eb;
    check("bundle", dut_bnd(), eb);
  endtask

  task automatic wr(input logic [3:0] r, input logic [15:0] v);
    idle();
    writeEn = 1; dest = r; writeVal = v;
    step();
  endtask

  vec_t tv [13];

  initial begin
    tv[0]  = '{16'h0093,1,0,0,0,0,     0,0,0,0, 0,0,1,1,16'd5,16'd7};
    tv[1]  = '{16'h2239,1,0,0,0,0,     0,0,0,0, 0,0,1,1,16'd7,16'd5};
    tv[2]  = '{16'h0093,1,0,1,3,16'hBEEF,0,0,0,0,0,0,1,1,16'd5,16'hBEEF};
    tv[3]  = '{16'h5093,1,0,0,0,0,     0,0,0,0, 0,0,1,0,16'd5,16'hBEEF};
    tv[4]  = '{16'h610D,1,0,0,0,0,     0,0,0,0, 0,0,1,1,16'd0,16'd0};
    tv[5]  = '{16'hF093,1,0,0,0,0,     0,0,0,0, 0,0,1,0,16'd5,16'hBEEF};
    tv[6]  = '{16'h0093,0,0,0,0,0,     0,0,0,0, 0,0,0,0,16'd0,16'd0};
    tv[7]  = '{16'hC290,1,0,0,0,0,     0,0,0,0, 0,0,1,1,16'd5,16'd0};
    tv[8]  = '{16'hD390,1,0,0,0,0,     0,0,0,0, 0,0,1,0,16'd5,16'hBEEF};
    tv[9]  = '{16'h0093,1,0,0,0,0,     1,1,9,0, 1,0,0,0,16'd0,16'd0};
    tv[10] = '{16'h900D,1,0,0,0,0,     0,0,0,0, 0,1,1,0,16'd0,16'd0};
    tv[11] = '{16'h800D,1,0,0,0,0,     0,0,0,0, 0,0,1,0,16'd0,16'd0};
    tv[12] = '{16'h0093,1,0,0,0,0,     0,0,0,1, 0,0,1,0,16'd0,16'd0};

    idle();
    rst = 0;
    m_ex = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    #1;
    check("reset_bundle", dut_bnd(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;

    wr(4'd9, 16'd5);
    wr(4'd3, 16'd7);
    wr(4'd1, 16'h1234);
    idle();
    step();

    for (int i = 0; i < 13; i++) begin
      idle();
      instruction = tv[i].instr;  in_valid = tv[i].iv;
      flagZ = tv[i].fz;           writeEn = tv[i].we;
      dest = tv[i].wd;            writeVal = tv[i].wv;
      MEM_R_EN_EXE = tv[i].mre;   WB_EN_EXE = tv[i].wbe;
      dest_EXE = tv[i].de;        ex_stall = tv[i].stall;
      #1;
      check($sformatf("tv%0d_hz", i), hazard_detected, tv[i].e_hz);
      check($sformatf("tv%0d_br", i), brTaken, tv[i].e_br);
      step();
      check($sformatf("tv%0d_out", i),
            {ex_valid, ex_WB_EN, ex_val1, ex_val2},
            {tv[i].e_valid, tv[i].e_wb, tv[i].e_v1, tv[i].e_v2});
    end

    // Branch decisions and the CMP flag stall
    idle();
    step();
    instruction = 16'h800D; in_valid = 1; flagZ = 1;
    #1;
    check("beq_taken", brTaken, 1'b1);
    check("br_offset", br_offset, 16'hFFFD);
    step();
    flagZ = 0;
    #1;
    check("beq_not_taken", brTaken, 1'b0);
    step();
    instruction = 16'h5012;
    step();
    instruction = 16'h800D; flagZ = 1;
    #1;
    check("flag_hz", {hazard_detected, brTaken, id_stall}, 3'b101);
    step();
    check("flag_bubble", ex_valid, 1'b0);
    #1;
    check("flag_clear", {hazard_detected, brTaken}, 2'b01);
    step();
    check("br_issue", {ex_valid, ex_EXE_CMD, ex_WB_EN}, 6'b1_1000_0);

    // Back-pressure for three cycles while WB keeps writing R5
    idle();
    instruction = 16'h0093; in_valid = 1;
    step();
    for (int k = 0; k < 3; k++) begin
      idle();
      ex_stall = 1; in_valid = 1; instruction = 16'h800D; flagZ = 1;
      writeEn = 1; dest = 4'd5; writeVal = 16'h1000 + 16'(k);
      #1;
      check("bp_stall", {id_stall, brTaken}, 2'b10);
      step();
      check("bp_hold", {ex_valid, ex_EXE_CMD, ex_val1}, {1'b1, 4'd0, 16'd5});
    end
    idle();
    instruction = 16'h7050; in_valid = 1;
    step();
    check("bp_wr_done", ex_val1, 16'h1002);

    // Load-use stall then issue with the load now in MEM
    idle();
    instruction = 16'h0093; in_valid = 1;
    MEM_R_EN_EXE = 1; WB_EN_EXE = 1; dest_EXE = 4'd9;
    #1;
    check("lu_hz", hazard_detected, 1'b1);
    step();
    check("lu_bubble", ex_valid, 1'b0);
    MEM_R_EN_EXE = 0; WB_EN_EXE = 0; dest_EXE = 4'd0;
    dest_MEM = 4'd9; WB_EN_MEM = 1;
    #1;
`ifdef ID_FORWARD_EN
    check("lu_clear", hazard_detected, 1'b0);
    step();
    check("lu_fwd", {ex_valid, ex_fwd_sel1}, 3'b1_10);
`else
    check("raw_mem_hz", hazard_detected, 1'b1);
    step();
    WB_EN_MEM = 0;
    #1;
    check("raw_clear", hazard_detected, 1'b0);
    step();
    check("raw_issue", {ex_valid, ex_fwd_sel1, ex_val1}, {3'b1_00, 16'd5});
`endif

    // Asynchronous reset mid-run with a valid entry in ID/EX
    idle();
    instruction = 16'h0010; in_valid = 1;
    step();
    check("pre_rst_valid", ex_valid, 1'b1);
    #2;
    rst = 0;
    #1;
    check("rst_async", dut_bnd(), '0);
    m_ex = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    idle();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    instruction = 16'h0010; in_valid = 1;
    step();
    check("r1_after_rst", {ex_valid, ex_val1}, {1'b1, 16'd0});

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      instruction = {4'($urandom), 2'b00, 2'($urandom),
                     2'b00, 2'($urandom), 4'($urandom)};
      in_valid     = ($urandom_range(0, 9) < 8);
      writeEn      = 1'($urandom);
      dest         = 4'($urandom_range(0, 3));
      writeVal     = 16'($urandom);
      dest_EXE     = 4'($urandom_range(0, 3));
      WB_EN_EXE    = 1'($urandom);
      MEM_R_EN_EXE = ($urandom_range(0, 9) < 3);
      dest_MEM     = 4'($urandom_range(0, 3));
      WB_EN_MEM    = 1'($urandom);
      flagZ        = 1'($urandom);
      ex_stall     = ($urandom_range(0, 9) < 2);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised instruction-decode stage with integrated register file, hazard unit and ID/EX pipeline register. It sits between the IF/ID register and the EXE stage. It decodes one instruction per cycle, reads operands with write-through bypass, and resolves BEQ/BNE in ID. It stalls on load-use and flag hazards, applies back-pressure from EXE, and presents a registered, valid-tagged bundle to EXE.

## Interface
- WORD_LEN, 16, instruction width; must be ≥ 4 + 3·REG_FILE_ADDR_LEN
- REG_FILE_SIZE, 16, register/data width
- REG_FILE_ADDR_LEN, 4, register index width; depth = 2^REG_FILE_ADDR_LEN
- EXE_CMD_LEN, 4, EXE command width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction from IF/ID valid
- instruction  in  WORD_LEN  fields: [W-1:W-4] opcode, then rd, rs1, rs2/imm (each REG_FILE_ADDR_LEN bits), MSB-first
- writeEn, dest, writeVal  in  1/ADDR/SIZE  WB write port
- dest_EXE, WB_EN_EXE, MEM_R_EN_EXE  in  ADDR/1/1  instruction currently in EXE
- dest_MEM, WB_EN_MEM  in  ADDR/1  instruction currently in MEM
- flagZ  in  1  architected zero flag
- ex_stall  in  1  EXE cannot accept; hold ID/EX
- id_stall  out  1  IF must hold the current instruction (= hazard_detected | ex_stall)
- hazard_detected  out  1  combinational load-use or flag hazard
- brTaken  out  1  combinational branch taken; br_offset  out  SIZE  sign-extended imm
- ex_valid, ex_EXE_CMD, ex_MEM_R_EN, ex_MEM_W_EN, ex_WB_EN, ex_is_imm, ex_dest, ex_src1, ex_src2, ex_val1, ex_val2, ex_imm  out  registered ID/EX bundle
- ex_fwd_sel1, ex_fwd_sel2  out  2  registered: 00 regfile, 01 EXE result, 10 MEM result

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 CMP: WB except CMP; CMP sets flag only.
  - 0110 MOVI: is_imm, WB.
  - 0111 MOVR: WB.
  - 1000 BEQ, 1001 BNE: no WB.
  - 1100 LOAD: MEM_R_EN, WB.
  - 1101 STORE: MEM_W_EN; val2 = rd value.
  - Any other opcode decodes as NOP: all enables 0, ex_valid 1.
- EXE_CMD equals the opcode zero-extended to EXE_CMD_LEN.
- Register file:
  - 2^ADDR × SIZE entries.
  - R0 reads 0; writes to R0 are ignored.
  - Writes occur at the rising edge when writeEn=1.
  - A read of `dest` in the same cycle as a write returns writeVal (bypass).
- Imm is rs2 field sign-extended to SIZE.
- Load-use hazard: in_valid & MEM_R_EN_EXE & WB_EN_EXE & dest_EXE≠0 & dest_EXE matches a source the instruction uses.
- Flag hazard: in_valid & branch opcode & ex_valid & ex_EXE_CMD==CMP.
- During a hazard (and ex_stall=0):
  - ID/EX loads a bubble: ex_valid=0 and all enables 0.
  - brTaken=0.
- ex_stall=1: ID/EX holds all fields; brTaken is forced 0.
- brTaken = in_valid & ~hazard & ~ex_stall & ((BEQ & flagZ) | (BNE & ~flagZ)). The branch itself passes into ID/EX as a no-WB entry.
- in_valid=0 with no stall: bubble loaded.

## Timing
- Decode and hazard logic are combinational within the cycle the instruction is presented. The bundle is visible on ex_* after the next rising edge (latency 1).
- A load-use stall lasts exactly 1 cycle: the load advances to MEM, and the hazard clears.
- A flag stall lasts 1 cycle.
- Reset (rst=0, asynchronous, any time):
  - All ex_* outputs go to 0, including ex_valid and fwd_sel.
  - Every register-file entry goes to 0.
  - Combinational outputs follow their inputs.
  - An in-flight ID/EX entry is discarded.
- Release of rst is synchronised externally. The first capture occurs at the first rising edge with rst=1.

## Configuration
- ID_FORWARD_EN defined:
  - ex_fwd_sel computed per source with EXE priority: 01 if WB_EN_EXE & dest_EXE==src & src≠0; else 10 on the MEM match; else 00.
  - Only load-use and flag hazards stall.
- ID_FORWARD_EN undefined:
  - ex_fwd_sel tied to 00.
  - hazard_detected additionally asserts on any RAW match against an EXE or MEM destination with WB enabled (src≠0).
  - The stall repeats until the producer retires.

## Test plan
- Reset: drive rst=0 mid-run with ex_valid=1 → all ex_* = 0 immediately. After release, reading R1 returns 0.
- ADD with instruction 16'h0093 and R9=5, R3=7 preloaded → next edge: ex_EXE_CMD=0, ex_dest=0, ex_val1=5, ex_val2=7, ex_WB_EN=1, ex_valid=1.
- Same-cycle bypass: writeEn=1, dest=3, writeVal=16'hBEEF while decoding a read of R3 → ex_val2=16'hBEEF.
- Load-use: MEM_R_EN_EXE=1, WB_EN_EXE=1, dest_EXE=9, instruction reads R9 → hazard_detected=1 for one cycle and a bubble is loaded. Next cycle the instruction issues with ex_fwd_sel1=10 (ID_FORWARD_EN defined).
- Branch: BEQ with flagZ=1 → brTaken=1 and br_offset equals sign-extended imm 4'b1101 = 16'hFFFD. With flagZ=0 → brTaken=0. With a CMP in ID/EX → 1-cycle stall, then the decision is made.
- Back-pressure: ex_stall=1 for 3 cycles → ex_* unchanged, id_stall=1, brTaken=0, register-file writes still performed.
